// File: rtl/core_pkg.sv
// Shared pipeline types for the RV32I core: result-mux encodings, field widths
// and the control bundle carried through ID/EX and EX/MEM.
// Contents: RES_* encodings, ALU_CTRL_W/REG_IDX_W, ctrl_bundle_t, mask_ctrl().
package core_pkg;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam int ALU_CTRL_W = 4;
    localparam int REG_IDX_W  = 5;

    typedef struct packed {
        logic                  reg_write;
        logic [1:0]            result_src;
        logic                  mem_write;
        logic                  jump;
        logic                  branch;
        logic [ALU_CTRL_W-1:0] alu_control;
        logic                  alu_src;
        logic [2:0]            funct3;
    } ctrl_bundle_t;

    // An invalid slot must never change architectural state or redirect the PC,
    // so every side-effecting control bit is cleared when valid is low.
    function automatic ctrl_bundle_t mask_ctrl(input ctrl_bundle_t c, input logic valid);
        ctrl_bundle_t m;
        m = c;
        if (!valid) begin
            m.reg_write = 1'b0;
            m.mem_write = 1'b0;
            m.jump      = 1'b0;
            m.branch    = 1'b0;
        end
        return m;
    endfunction

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register with hold (en low) and synchronous clear.
// Latency: 1 cycle d->q. Backpressure: en=0 holds q; clr only acts when en=1.
// Ports: clk, rst (sync, active-high), en, clr, d[W-1:0] -> q[W-1:0].
module pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            if (clr) q <= '0;
            else     q <= d;
        end
    end

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register: captures the decoded D bundle and presents it to execute.
// Latency: 1 cycle D->E, all outputs registered. Backpressure: StallE holds E, FlushE loads a bubble.
// Ports: clk/rst, StallE/FlushE/ValidD, D bundle in -> E bundle, ValidE, BubbleCountE, StallCountE.
module id_ex_pipe
    import core_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  StallE,
    input  logic                  FlushE,
    input  logic                  ValidD,
    input  logic [DATA_WIDTH-1:0] RD1D,
    input  logic [DATA_WIDTH-1:0] RD2D,
    input  logic [DATA_WIDTH-1:0] ExtImmD,
    input  logic [DATA_WIDTH-1:0] PCD,
    input  logic [DATA_WIDTH-1:0] PCPlus4D,
    input  logic [REG_IDX_W-1:0]  Rs1D,
    input  logic [REG_IDX_W-1:0]  Rs2D,
    input  logic [REG_IDX_W-1:0]  RdD,
    input  logic                  RegWriteD,
    input  logic                  MemWriteD,
    input  logic                  JumpD,
    input  logic                  BranchD,
    input  logic                  ALUSrcD,
    input  logic [1:0]            ResultSrcD,
    input  logic [ALU_CTRL_W-1:0] ALUControlD,
    input  logic [2:0]            Funct3D,
    output logic [DATA_WIDTH-1:0] RD1E,
    output logic [DATA_WIDTH-1:0] RD2E,
    output logic [DATA_WIDTH-1:0] ExtImmE,
    output logic [DATA_WIDTH-1:0] PCE,
    output logic [DATA_WIDTH-1:0] PCPlus4E,
    output logic [REG_IDX_W-1:0]  Rs1E,
    output logic [REG_IDX_W-1:0]  Rs2E,
    output logic [REG_IDX_W-1:0]  RdE,
    output logic                  RegWriteE,
    output logic                  MemWriteE,
    output logic                  JumpE,
    output logic                  BranchE,
    output logic                  ALUSrcE,
    output logic [1:0]            ResultSrcE,
    output logic [ALU_CTRL_W-1:0] ALUControlE,
    output logic [2:0]            Funct3E,
    output logic                  ValidE,
    output logic [CNT_WIDTH-1:0]  BubbleCountE,
    output logic [CNT_WIDTH-1:0]  StallCountE
);

    localparam int DATA_W = 5 * DATA_WIDTH + 3 * REG_IDX_W;
    localparam int CTRL_W = $bits(ctrl_bundle_t) + 1;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] data_d, data_q;
    logic [CTRL_W-1:0] ctrl_reg_d, ctrl_reg_q;
    ctrl_bundle_t      ctrl_d, ctrl_q;
    logic              valid_q;
    logic              bubble_inc;

    // ---------------- data bundle ----------------
    assign data_d = {RD1D, RD2D, ExtImmD, PCD, PCPlus4D, Rs1D, Rs2D, RdD};

    pipe_reg #(.W(DATA_W)) u_data_reg (
        .clk (clk),
        .rst (rst),
        .en  (~StallE),
        .clr (FlushE),
        .d   (data_d),
        .q   (data_q)
    );

    assign {RD1E, RD2E, ExtImmE, PCE, PCPlus4E, Rs1E, Rs2E, RdE} = data_q;

    // ---------------- control bundle + valid ----------------
    assign ctrl_d = '{
        reg_write:   RegWriteD,
        result_src:  ResultSrcD,
        mem_write:   MemWriteD,
        jump:        JumpD,
        branch:      BranchD,
        alu_control: ALUControlD,
        alu_src:     ALUSrcD,
        funct3:      Funct3D
    };

    assign ctrl_reg_d = {mask_ctrl(ctrl_d, ValidD), ValidD};

    pipe_reg #(.W(CTRL_W)) u_ctrl_reg (
        .clk (clk),
        .rst (rst),
        .en  (~StallE),
        .clr (FlushE),
        .d   (ctrl_reg_d),
        .q   (ctrl_reg_q)
    );

    assign {ctrl_q, valid_q} = ctrl_reg_q;

    assign RegWriteE   = ctrl_q.reg_write;
    assign ResultSrcE  = ctrl_q.result_src;
    assign MemWriteE   = ctrl_q.mem_write;
    assign JumpE       = ctrl_q.jump;
    assign BranchE     = ctrl_q.branch;
    assign ALUControlE = ctrl_q.alu_control;
    assign ALUSrcE     = ctrl_q.alu_src;
    assign Funct3E     = ctrl_q.funct3;
    assign ValidE      = valid_q;

    // ---------------- performance counters ----------------
    // A bubble is anything non-real entering E: an explicit flush or an
    // invalid D slot. Gating on !StallE keeps the two counters exclusive.
    assign bubble_inc = !StallE && (FlushE || !ValidD);

    always_ff @(posedge clk) begin
        if (rst) begin
            StallCountE  <= '0;
            BubbleCountE <= '0;
        end else begin
            if (StallE && (StallCountE != CNT_MAX))
                StallCountE <= StallCountE + CNT_ONE;
            if (bubble_inc && (BubbleCountE != CNT_MAX))
                BubbleCountE <= BubbleCountE + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_id_ex_pipe.sv
// Scoreboard bench for id_ex_pipe: the driver applies one D vector per cycle and
// queues the hand-computed E state expected after the next edge; a monitor pops
// and compares after every edge. A CNT_WIDTH=4 instance shares the stimulus.
module tb_id_ex_pipe;
    import core_pkg::*;

    localparam int DW = 32;

    typedef struct {
        logic        rst, stall, flush, valid;
        logic [31:0] rd1, rd2, imm, pc, pc4;
        logic [4:0]  rs1, rs2, rd;
        logic        regw, memw, jump, branch, alusrc;
        logic [1:0]  ressrc;
        logic [3:0]  aluc;
        logic [2:0]  f3;
    } dv_t;

    typedef struct {
        logic [31:0] rd1, rd2, imm, pc;
        logic [4:0]  rd;
        logic        regw, memw, jump, valid;
        logic [1:0]  ressrc;
        logic [31:0] bub, stl;
        logic [50:0] sec;
    } exp_t;

    logic clk = 1'b0;
    logic rst, StallE, FlushE, ValidD;
    logic [DW-1:0] RD1D, RD2D, ExtImmD, PCD, PCPlus4D;
    logic [4:0] Rs1D, Rs2D, RdD;
    logic RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
    logic [1:0] ResultSrcD;
    logic [3:0] ALUControlD;
    logic [2:0] Funct3D;

    logic [DW-1:0] RD1E, RD2E, ExtImmE, PCE, PCPlus4E;
    logic [4:0] Rs1E, Rs2E, RdE;
    logic RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ValidE;
    logic [1:0] ResultSrcE;
    logic [3:0] ALUControlE;
    logic [2:0] Funct3E;
    logic [31:0] BubbleCountE, StallCountE;

    logic [DW-1:0] s_rd1, s_rd2, s_imm, s_pc, s_pc4;
    logic [4:0] s_rs1, s_rs2, s_rd;
    logic s_regw, s_memw, s_jump, s_branch, s_alusrc, s_valid;
    logic [1:0] s_ressrc;
    logic [3:0] s_aluc;
    logic [2:0] s_f3;
    logic [3:0] s_bub, s_stl;

    int   n_chk = 0;
    int   n_err = 0;
    exp_t q[$];
    exp_t me;

    always #5 clk = ~clk;

    id_ex_pipe #(.DATA_WIDTH(DW), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
        .RD1D(RD1D), .RD2D(RD2D), .ExtImmD(ExtImmD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD),
        .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD), .Funct3D(Funct3D),
        .RD1E(RD1E), .RD2E(RD2E), .ExtImmE(ExtImmE), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
        .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .Funct3E(Funct3E),
        .ValidE(ValidE), .BubbleCountE(BubbleCountE), .StallCountE(StallCountE)
    );

    id_ex_pipe #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) u_sat (
        .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
        .RD1D(RD1D), .RD2D(RD2D), .ExtImmD(ExtImmD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD),
        .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD), .Funct3D(Funct3D),
        .RD1E(s_rd1), .RD2E(s_rd2), .ExtImmE(s_imm), .PCE(s_pc), .PCPlus4E(s_pc4),
        .Rs1E(s_rs1), .Rs2E(s_rs2), .RdE(s_rd),
        .RegWriteE(s_regw), .MemWriteE(s_memw), .JumpE(s_jump), .BranchE(s_branch),
        .ALUSrcE(s_alusrc), .ResultSrcE(s_ressrc), .ALUControlE(s_aluc), .Funct3E(s_f3),
        .ValidE(s_valid), .BubbleCountE(s_bub), .StallCountE(s_stl)
    );

    // D vector: key fields given explicitly, the rest derived so each vector is distinct.
    function automatic dv_t mkv(input logic valid, input logic [31:0] rd1, rd2, imm, pc,
                                input logic [4:0] rd, input logic regw, memw, jump,
                                input logic [1:0] rs);
        dv_t d;
        d.rst = 1'b0; d.stall = 1'b0; d.flush = 1'b0; d.valid = valid;
        d.rd1 = rd1; d.rd2 = rd2; d.imm = imm; d.pc = pc; d.pc4 = pc + 32'd4;
        d.rs1 = rd + 5'd1; d.rs2 = rd + 5'd2; d.rd = rd;
        d.regw = regw; d.memw = memw; d.jump = jump; d.branch = ~jump; d.alusrc = regw;
        d.ressrc = rs; d.aluc = rd[3:0]; d.f3 = rd[2:0];
        return d;
    endfunction

    function automatic dv_t ones_v();
        dv_t d;
        d.rst = 1'b1; d.stall = 1'b1; d.flush = 1'b1; d.valid = 1'b1;
        d.rd1 = '1; d.rd2 = '1; d.imm = '1; d.pc = '1; d.pc4 = '1;
        d.rs1 = '1; d.rs2 = '1; d.rd = '1;
        d.regw = 1'b1; d.memw = 1'b1; d.jump = 1'b1; d.branch = 1'b1; d.alusrc = 1'b1;
        d.ressrc = '1; d.aluc = '1; d.f3 = '1;
        return d;
    endfunction

    // Secondary fields of a loaded vector; branch is a control bit and is masked when invalid.
    function automatic logic [50:0] sec_of(input dv_t d);
        return {d.pc4, d.rs1, d.rs2, d.aluc, d.f3, d.alusrc, d.branch & d.valid};
    endfunction

    function automatic exp_t mke(input logic [31:0] rd1, rd2, imm, pc, input logic [4:0] rd,
                                 input logic regw, memw, jump, input logic [1:0] rs,
                                 input logic valid, input logic [31:0] bub, stl,
                                 input logic [50:0] sec);
        exp_t e;
        e.rd1 = rd1; e.rd2 = rd2; e.imm = imm; e.pc = pc; e.rd = rd;
        e.regw = regw; e.memw = memw; e.jump = jump; e.ressrc = rs; e.valid = valid;
        e.bub = bub; e.stl = stl; e.sec = sec;
        return e;
    endfunction

    function automatic exp_t mkz(input logic [31:0] bub, stl);
        return mke('0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, bub, stl, '0);
    endfunction

    function automatic logic [63:0] sat4(input logic [31:0] v);
        return (v > 32'd15) ? 64'd15 : {32'd0, v};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic step(input dv_t d, input exp_t e);
        @(negedge clk);
        rst = d.rst; StallE = d.stall; FlushE = d.flush; ValidD = d.valid;
        RD1D = d.rd1; RD2D = d.rd2; ExtImmD = d.imm; PCD = d.pc; PCPlus4D = d.pc4;
        Rs1D = d.rs1; Rs2D = d.rs2; RdD = d.rd;
        RegWriteD = d.regw; MemWriteD = d.memw; JumpD = d.jump; BranchD = d.branch;
        ALUSrcD = d.alusrc; ResultSrcD = d.ressrc; ALUControlD = d.aluc; Funct3D = d.f3;
        q.push_back(e);
    endtask

    // Monitor: one expectation per edge, checked 1 time unit after it.
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            me = q.pop_front();
            chk("rd1",       {32'd0, RD1E},          {32'd0, me.rd1});
            chk("rd2",       {32'd0, RD2E},          {32'd0, me.rd2});
            chk("imm",       {32'd0, ExtImmE},       {32'd0, me.imm});
            chk("pc",        {32'd0, PCE},           {32'd0, me.pc});
            chk("rd",        {59'd0, RdE},           {59'd0, me.rd});
            chk("regwrite",  {63'd0, RegWriteE},     {63'd0, me.regw});
            chk("memwrite",  {63'd0, MemWriteE},     {63'd0, me.memw});
            chk("jump",      {63'd0, JumpE},         {63'd0, me.jump});
            chk("resultsrc", {62'd0, ResultSrcE},    {62'd0, me.ressrc});
            chk("valid",     {63'd0, ValidE},        {63'd0, me.valid});
            chk("bubbles",   {32'd0, BubbleCountE},  {32'd0, me.bub});
            chk("stalls",    {32'd0, StallCountE},   {32'd0, me.stl});
            chk("secondary", {13'd0, PCPlus4E, Rs1E, Rs2E, ALUControlE, Funct3E, ALUSrcE, BranchE},
                             {13'd0, me.sec});
            chk("sat_bubbles", {60'd0, s_bub},   sat4(me.bub));
            chk("sat_stalls",  {60'd0, s_stl},   sat4(me.stl));
            chk("sat_valid",   {63'd0, s_valid}, {63'd0, me.valid});
            if (ValidE == 1'b0)
                chk("bubble_ctrl", {60'd0, RegWriteE, MemWriteE, JumpE, BranchE}, 64'd0);
        end
    end

    initial begin
        dv_t v1, v2, v3, v4, v5, v6, d;
        rst = 1'b1; StallE = 1'b0; FlushE = 1'b0; ValidD = 1'b0;
        RD1D = '0; RD2D = '0; ExtImmD = '0; PCD = '0; PCPlus4D = '0;
        Rs1D = '0; Rs2D = '0; RdD = '0;
        RegWriteD = 1'b0; MemWriteD = 1'b0; JumpD = 1'b0; BranchD = 1'b0; ALUSrcD = 1'b0;
        ResultSrcD = '0; ALUControlD = '0; Funct3D = '0;

        v1 = mkv(1'b1, 32'h11, 32'h22, 32'hFFFF_F800, 32'h100, 5'd5, 1'b1, 1'b0, 1'b0, RES_ALU);
        v2 = mkv(1'b1, 32'h33, 32'h44, 32'h7,         32'h104, 5'd6, 1'b0, 1'b1, 1'b0, RES_MEM);
        v3 = mkv(1'b1, 32'hDEAD, 32'hBEEF, 32'h5,     32'h200, 5'd9, 1'b1, 1'b1, 1'b1, RES_PC4);
        v4 = mkv(1'b1, 32'h55, 32'hAB, 32'h9,         32'h108, 5'd7, 1'b1, 1'b1, 1'b1, RES_PC4);
        v5 = mkv(1'b0, 32'h66, 32'h77, 32'h1,         32'h10C, 5'd8, 1'b1, 1'b1, 1'b1, RES_PC4);
        v6 = mkv(1'b1, 32'h88, 32'h99, 32'hA,         32'h110, 5'd9, 1'b1, 1'b0, 1'b1, RES_PC4);

        // Reset with every D input high and stall/flush asserted.
        step(ones_v(), mkz(0, 0));
        step(ones_v(), mkz(0, 0));

        // Normal load.
        step(v1, mke(32'h11, 32'h22, 32'hFFFF_F800, 32'h100, 5'd5, 1'b1, 1'b0, 1'b0, RES_ALU, 1'b1, 0, 0, sec_of(v1)));

        // Load v2, then hold it for 3 stall cycles while D changes.
        step(v2, mke(32'h33, 32'h44, 32'h7, 32'h104, 5'd6, 1'b0, 1'b1, 1'b0, RES_MEM, 1'b1, 0, 0, sec_of(v2)));
        for (int i = 1; i <= 3; i++) begin
            d = v3; d.stall = 1'b1;
            step(d, mke(32'h33, 32'h44, 32'h7, 32'h104, 5'd6, 1'b0, 1'b1, 1'b0, RES_MEM, 1'b1, 0, i, sec_of(v2)));
        end

        // Flush: MemWriteD=1, RD2D=0xAB must not survive.
        d = v4; d.flush = 1'b1;
        step(d, mkz(1, 3));

        // Invalid D slot: data passes, controls masked, counted as a bubble.
        step(v5, mke(32'h66, 32'h77, 32'h1, 32'h10C, 5'd8, 1'b0, 1'b0, 1'b0, RES_PC4, 1'b0, 2, 3, sec_of(v5)));

        // Stall+flush collision: stall wins, then flush lands.
        step(v6, mke(32'h88, 32'h99, 32'hA, 32'h110, 5'd9, 1'b1, 1'b0, 1'b1, RES_PC4, 1'b1, 2, 3, sec_of(v6)));
        d = v3; d.stall = 1'b1; d.flush = 1'b1;
        step(d, mke(32'h88, 32'h99, 32'hA, 32'h110, 5'd9, 1'b1, 1'b0, 1'b1, RES_PC4, 1'b1, 2, 4, sec_of(v6)));
        d = v3; d.flush = 1'b1;
        step(d, mkz(3, 4));

        // 20 consecutive flushes: the 4-bit instance stops at 15.
        for (int i = 0; i < 20; i++) begin
            d = v4; d.flush = 1'b1;
            step(d, mkz(4 + i, 4));
        end

        // Load, stall twice, then reset in the middle of the stall.
        step(v6, mke(32'h88, 32'h99, 32'hA, 32'h110, 5'd9, 1'b1, 1'b0, 1'b1, RES_PC4, 1'b1, 23, 4, sec_of(v6)));
        for (int i = 5; i <= 6; i++) begin
            d = v3; d.stall = 1'b1;
            step(d, mke(32'h88, 32'h99, 32'hA, 32'h110, 5'd9, 1'b1, 1'b0, 1'b1, RES_PC4, 1'b1, 23, i, sec_of(v6)));
        end
        d = v3; d.stall = 1'b1; d.rst = 1'b1;
        step(d, mkz(0, 0));

        // Normal operation resumes from zeroed counters.
        step(v1, mke(32'h11, 32'h22, 32'hFFFF_F800, 32'h100, 5'd5, 1'b1, 1'b0, 1'b0, RES_ALU, 1'b1, 0, 0, sec_of(v1)));

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #2;
        n_chk++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
- ID/EX pipeline register of the pipelined RV32I core, directly downstream of the immediate extender and register file.
- Captures the decoded instruction bundle (operands, ExtImmD, PC values, register indices, control) on each rising edge and presents it to the execute stage.
- Supports a stall (hold), a flush (bubble insertion) and a valid bit.
- Keeps saturating bubble and stall performance counters.

Parameters:
- DATA_WIDTH, 32, width of operand, immediate and PC fields.
- CNT_WIDTH, 32, width of each performance counter.

Ports:
- clk  input  1  core clock, rising edge
- rst  input  1  synchronous reset, active-high
- StallE  input  1  hold all E-stage contents
- FlushE  input  1  load a bubble instead of the D bundle
- ValidD  input  1  D bundle holds a real instruction
- RD1D, RD2D  input  DATA_WIDTH each  register file read data
- ExtImmD  input  DATA_WIDTH  extended immediate
- PCD, PCPlus4D  input  DATA_WIDTH each  instruction PC and PC+4
- Rs1D, Rs2D, RdD  input  5 each  register indices
- RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD  input  1 each  control
- ResultSrcD  input  2  result mux select
- ALUControlD  input  4  ALU operation
- Funct3D  input  3  branch/load/store sub-op
- Each D input above has a matching E output of identical width (RD1E ... Funct3E).
- ValidE  output  1  E bundle is a real instruction
- BubbleCountE  output  CNT_WIDTH  bubbles loaded into E
- StallCountE  output  CNT_WIDTH  cycles E was held

Behaviour:
- All state updates on the rising edge of clk. Latency is one cycle from D inputs to E outputs.
- Priority per edge: rst > StallE > FlushE > normal load.
- rst=1: every E output, ValidE and both counters go to 0. This applies regardless of StallE/FlushE and mid-stall or mid-flush. The first post-reset cycle presents a bubble.
- StallE=1 (rst=0): all E fields and ValidE hold their values. StallCountE increments. BubbleCountE holds.
- StallE=1 with FlushE=1: stall wins and the flush is ignored that cycle. The hazard unit keeps FlushE asserted until StallE drops.
- FlushE=1, StallE=0: every E field is loaded with 0, including data fields, so a bubble is fully deterministic. ValidE=0, ResultSrcE=00. BubbleCountE increments.
- Normal load (StallE=0, FlushE=0): every E field takes its D input and ValidE<=ValidD.
  - If ValidD=0, all control outputs (RegWriteE, MemWriteE, JumpE, BranchE) are forced to 0 regardless of their D values.
  - A bubble is counted (BubbleCountE increments).
- A bubble never writes state: RegWriteE=MemWriteE=JumpE=BranchE=0 whenever ValidE=0. Verification checks this as an invariant.
- Counters saturate at 2^CNT_WIDTH-1 with no wrap-around.
- StallCountE and BubbleCountE never increment in the same cycle.
- No combinational path from any input to any output.

Decomposition:
- Shared package core_pkg holds:
  - ResultSrc encodings: RES_ALU=00, RES_MEM=01, RES_PC4=10.
  - ALU_CTRL_W=4 and REG_IDX_W=5.
  - Packed struct ctrl_bundle_t (RegWrite, ResultSrc, MemWrite, Jump, Branch, ALUControl, ALUSrc, Funct3). The same struct is reused by the EX/MEM register.
- One natural sub-module, pipe_reg:
  - Parameterised width, with enable and synchronous clear, clear below enable in priority.
  - Instantiated once for the data bundle and once for ctrl_bundle_t+valid.
  - Counters stay in id_ex_pipe.

Test Plan:
- Reset: drive all D inputs to 1s, StallE=FlushE=1, assert rst 2 cycles -> all E outputs, ValidE and both counters read 0.
- Normal flow: ValidD=1, RD1D=0x11, ExtImmD=0xFFFFF800, RdD=5, RegWriteD=1 -> next cycle RD1E=0x11, ExtImmE=0xFFFFF800, RdE=5, RegWriteE=1, ValidE=1; counters remain 0.
- Stall: load one bundle, then StallE=1 for 3 cycles while the D inputs change -> E holds the original bundle; StallCountE=3, BubbleCountE=0.
- Flush and ValidD=0:
  - FlushE=1 with MemWriteD=1, RD2D=0xAB -> MemWriteE=0, RD2E=0, ValidE=0, BubbleCountE=1.
  - Then ValidD=0 with RegWriteD=1 -> RegWriteE=0, BubbleCountE=2.
- Stall+flush collision: StallE=1, FlushE=1 for 1 cycle -> E held, StallCountE+1, BubbleCountE unchanged; then StallE=0 with FlushE=1 -> bubble loaded.
- Saturation: CNT_WIDTH=4 build, 20 consecutive flush cycles -> BubbleCountE stops at 15. Then rst mid-stall -> both counters return to 0.
